// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, IR, fetch-address tracking and retired-fetch counter.
// Optional sticky PC wrap fault enabled by defining PC_WRAP_TRAP_EN.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_ld,
  input  logic        pc_inc,
  input  logic        pc_sel,
  input  logic        ir_ld,
  input  logic        adr_sel,
  input  logic [15:0] reg_adr,
  input  logic [15:0] jmp_tgt,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_adr,
  output logic [15:0] IR,
  output logic [15:0] PC,
  output logic [15:0] ir_pc,
  output logic [15:0] inst_cnt
`ifdef PC_WRAP_TRAP_EN
  ,
  output logic        pc_fault
`endif
);

  localparam int DATA_W = 16;

  logic        [DATA_W-1:0] pc_q, pc_d;
  logic        [DATA_W-1:0] ir_q, ir_d;
  logic        [DATA_W-1:0] ir_pc_q, ir_pc_d;
  logic        [DATA_W-1:0] cnt_q, cnt_d;
  logic signed [DATA_W-1:0] rel_off;
  logic        [DATA_W-1:0] rel_tgt;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign rel_off = DATA_W'(signed'(ir_q[7:0]));
  assign rel_tgt = pc_q + rel_off;
  assign mem_adr = adr_sel ? reg_adr : pc_q;

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    cnt_d   = cnt_q;
    if (pc_ld) begin
      pc_d = pc_sel ? jmp_tgt : rel_tgt;
    end else if (pc_inc) begin
      pc_d = pc_q + 1'b1;
    end
    if (ir_ld) begin
      ir_d    = mem_rdata;
      ir_pc_d = pc_q;
      cnt_d   = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      ir_pc_q <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC       = pc_q;
  assign IR       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign inst_cnt = cnt_q;

`ifdef PC_WRAP_TRAP_EN
  logic              fault_q, fault_d;
  logic [DATA_W:0]   rel_sum;
  logic              rel_wrap;
  logic              inc_wrap;

  // Positive offsets wrap on carry out; negative offsets wrap when no carry (borrow).
  assign rel_sum  = {1'b0, pc_q} + {1'b0, rel_off};
  assign rel_wrap = ir_q[7] ? ~rel_sum[DATA_W] : rel_sum[DATA_W];
  assign inc_wrap = (pc_q == {DATA_W{1'b1}});

  always_comb begin
    fault_d = fault_q;
    if (pc_ld && !pc_sel && rel_wrap) begin
      fault_d = 1'b1;
    end else if (!pc_ld && pc_inc && inc_wrap) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign pc_fault = fault_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 pc_ld  input  1  from control unit; load PC with a branch or jump target.
REQ-004 pc_inc  input  1  from control unit; PC <- PC+1.
REQ-005 pc_sel  input  1  target select: 0 = PC + sign-extended IR[7:0], 1 = jmp_tgt.
REQ-006 ir_ld  input  1  from control unit; IR <- mem_rdata.
REQ-007 adr_sel  input  1  memory address select: 0 = PC, 1 = reg_adr.
REQ-008 reg_adr  input  16  register-file R operand, used as the LD/STO data address.
REQ-009 jmp_tgt  input  16  register-file S operand, used as the JMP target.
REQ-010 mem_rdata  input  16  memory read data, combinational from mem_adr.
REQ-011 mem_adr  output  16  memory address.
REQ-012 IR  output  16  instruction register, to the control unit.
REQ-013 PC  output  16  program counter.
REQ-014 ir_pc  output  16  address the current IR contents were fetched from.
REQ-015 inst_cnt  output  16  count of retired fetches.
REQ-016 pc_fault  output  1  sticky PC wrap fault; present only under REQ-031.

Function
REQ-017 mem_adr SHALL be combinational: adr_sel ? reg_adr : PC.
REQ-018 On a clock edge with ir_ld=1, the block SHALL perform both updates: IR <= mem_rdata and ir_pc <= PC (the pre-update PC).
REQ-019 PC update priority SHALL be as follows.
- pc_ld=1, pc_sel=1: PC <= jmp_tgt.
- pc_ld=1, pc_sel=0: PC <= PC + {{8{IR[7]}}, IR[7:0]}.
- Otherwise, pc_inc=1: PC <= PC + 1.
- Otherwise: PC holds.
REQ-020 pc_ld SHALL take priority over pc_inc when both are asserted.
REQ-021 The relative target SHALL use the current PC, which already points past the branch instruction, and the current IR.
REQ-022 All PC arithmetic SHALL be modulo 2^16: FFFF+1 = 0000, and 0002 + se(FE) = 0000.
REQ-023 ir_ld and pc_inc asserted together, as in the FETCH cycle, SHALL load IR from M[old PC] and advance PC by one in the same edge.
REQ-024 inst_cnt SHALL increment by one on each ir_ld edge and saturate at FFFF (no wrap).
REQ-025 ir_ld SHALL NOT affect PC; pc_ld and pc_inc SHALL NOT affect IR or ir_pc.
REQ-026 Control inputs SHALL have single-cycle effect; the block SHALL hold no state beyond PC, IR, ir_pc, inst_cnt and pc_fault.

Reset
REQ-027 While reset=1 at a clock edge, PC, IR, ir_pc and inst_cnt SHALL be 16'h0000, and pc_fault SHALL be 0.
REQ-028 Reset SHALL override every simultaneous control input, including reset asserted mid-fetch with ir_ld=1 and pc_inc=1.
REQ-029 On the first edge after reset deasserts, the block SHALL respond normally; the first fetch reads M[0000].
REQ-030 mem_adr SHALL remain combinational during reset, equal to 0000 when adr_sel=0.

Configuration
REQ-031 Macro PC_WRAP_TRAP_EN SHALL control the wrap fault.
- Defined: pc_fault is set on any edge where a pc_inc or relative pc_ld update crosses from FFFF to 0000 (carry out) or from 0000 to FFFF (borrow). It stays set until reset.
- Defined: a pc_sel=1 jump never sets pc_fault.
- Not defined: the pc_fault port is absent, and wrap is silent.

Verification
REQ-032 Reset, then FETCH with mem_rdata=E1C2, ir_ld=1, pc_inc=1 -> IR=E1C2, ir_pc=0000, PC=0001, inst_cnt=0001.
REQ-033 PC=0010, IR=F805, pc_ld=1, pc_sel=0 -> PC=0015; with IR=F8FB -> PC=000B.
REQ-034 pc_ld=1, pc_sel=1, pc_inc=1, jmp_tgt=1234 -> PC=1234 (priority); adr_sel=1, reg_adr=00AA -> mem_adr=00AA.
REQ-035 PC=FFFF, pc_inc=1 -> PC=0000; pc_fault=1 with PC_WRAP_TRAP_EN defined and held until reset; port absent when undefined.
REQ-036 inst_cnt preset to FFFF via 65535 fetches, one more ir_ld -> inst_cnt stays FFFF.
REQ-037 reset=1 in the same cycle as ir_ld=1, pc_inc=1, mem_rdata=ABCD -> all registers 0000 and pc_fault=0 after the edge.
